// File: rtl/mer_meas_ctrl.sv
// mer_meas_ctrl: two-phase MER sequencer - mean |dec_var| sets ref_lvl, then mean squared slicer error.
// Optional build macro CONT_MEAS_EN: error windows repeat back-to-back with the held ref_lvl.
module mer_meas_ctrl #(
  parameter int LOG2_N   = 16,
  parameter int DW       = 18,
  parameter int REF_INIT = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_clk_en,
  input  logic                 start,
  input  logic signed [DW-1:0] dec_var,
  input  logic signed [DW-1:0] ref_map,
  output logic signed [DW-1:0] ref_lvl,
  output logic [1:0]           slice,
  output logic [2*DW-1:0]      err_sq_avg,
  output logic                 busy,
  output logic                 valid
);
  localparam int RAW = DW + LOG2_N;
  localparam int EAW = 2*DW + LOG2_N;
  localparam int CW  = LOG2_N + 1;
  localparam logic [CW-1:0]        LAST_CNT = {1'b0, {LOG2_N{1'b1}}};
  localparam logic signed [DW-1:0] S_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] REF_RST  = DW'(REF_INIT);

  typedef enum logic [1:0] {IDLE, REF_ACC, ERR_ACC, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [RAW-1:0]       ref_acc_q, ref_acc_d;
  logic [EAW-1:0]       err_acc_q, err_acc_d;
  logic signed [DW-1:0] ref_lvl_q, ref_lvl_d;
  logic [2*DW-1:0]      err_avg_q, err_avg_d;
  logic                 busy_q, valid_q;

  logic [DW-1:0]        abs_dv;
  logic [DW-1:0]        ref_mean;
  logic signed [DW:0]   dv_x, ref_x, err_w;
  logic signed [DW-1:0] err_sat;
  logic [2*DW-1:0]      err_x, err_sq;
  logic                 phase_end, restart;

  assign abs_dv    = (dec_var == S_MIN) ? S_MAX : (dec_var[DW-1] ? -dec_var : dec_var);
  assign ref_acc_d = ref_acc_q + {{LOG2_N{1'b0}}, abs_dv};
  assign ref_mean  = ref_acc_d[RAW-1:LOG2_N];
  assign ref_lvl_d = ref_mean[DW-1] ? S_MAX : $signed(ref_mean);

  assign dv_x  = {dec_var[DW-1], dec_var};
  assign ref_x = {ref_lvl_q[DW-1], ref_lvl_q};
  assign err_w = dv_x - {ref_map[DW-1], ref_map};
  assign err_sat = (err_w[DW] != err_w[DW-1]) ? (err_w[DW] ? S_MIN : S_MAX) : err_w[DW-1:0];

  // A two's-complement square taken modulo 2^(2*DW) is exact here since |e|^2 <= 2^(2*DW-2).
  assign err_x     = {{DW{err_sat[DW-1]}}, err_sat};
  assign err_sq    = err_x * err_x;
  assign err_acc_d = err_acc_q + {{LOG2_N{1'b0}}, err_sq};
  assign err_avg_d = err_acc_d[EAW-1:LOG2_N];

  always_comb begin
    slice = 2'b00;
    if (dv_x >= ref_x)        slice = 2'b10;
    else if (!dec_var[DW-1])  slice = 2'b11;
    else if (dv_x >= -ref_x)  slice = 2'b01;
  end

  assign phase_end = sam_clk_en && (cnt_q == LAST_CNT);

`ifdef CONT_MEAS_EN
  assign restart = start && (state_q != REF_ACC);
`else
  assign restart = start && ((state_q == IDLE) || (state_q == DONE));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_acc_q <= '0;
      err_acc_q <= '0;
      ref_lvl_q <= REF_RST;
      err_avg_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (restart) begin
      // A strobe coinciding with start is deliberately dropped.
      state_q   <= REF_ACC;
      cnt_q     <= '0;
      ref_acc_q <= '0;
      err_acc_q <= '0;
      busy_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else if (sam_clk_en) begin
      case (state_q)
        REF_ACC: begin
          if (phase_end) begin
            ref_lvl_q <= ref_lvl_d;
            ref_acc_q <= '0;
            cnt_q     <= '0;
            state_q   <= ERR_ACC;
          end else begin
            ref_acc_q <= ref_acc_d;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        ERR_ACC: begin
          if (phase_end) begin
            err_avg_q <= err_avg_d;
            err_acc_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b1;
`ifdef CONT_MEAS_EN
            state_q   <= ERR_ACC;
`else
            state_q   <= DONE;
            busy_q    <= 1'b0;
`endif
          end else begin
            err_acc_q <= err_acc_d;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ref_lvl    = ref_lvl_q;
  assign err_sq_avg = err_avg_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
endmodule

// File: doc/mer_meas_ctrl.md
Name: mer_meas_ctrl

Overview:
Sequencer for the MER measurement circuit. Runs a two-phase measurement over the 4-PAM decision variable. Phase one estimates the reference level (ref_lvl = 2b) as the mean |dec_var|. Phase two slices each symbol, drives ref_lvl and slice to the reference mapper, and accumulates the squared error against the mapper output, so software can compute MER from mean signal and error power.

Parameters:
LOG2_N, 16, log2 of symbols per measurement phase (N = 2^LOG2_N, same N for both phases)
DW, 18, sample width (1s17 format)
REF_INIT, 65536, reset and default ref_lvl (2b with b = 32768, matching the transmit mapper levels)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sam_clk_en  in  1  symbol strobe; all accumulation and advancement happens only on strobe cycles
start  in  1  single-cycle request to begin a measurement
dec_var  in  DW  signed decision variable, 1s17
ref_map  in  DW  signed mapped reference level returned by the reference mapper for the current slice/ref_lvl (combinational path)
ref_lvl  out  DW  signed reference level 2b, registered
slice  out  2  slicer decision: 00 = -3b, 01 = -b, 11 = +b, 10 = +3b; combinational from dec_var and ref_lvl
err_sq_avg  out  2*DW  mean squared error, 2s34, registered
busy  out  1  high in REF_ACC or ERR_ACC
valid  out  1  high while err_sq_avg holds a completed result

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high.
- Reset values: state IDLE, ref_lvl = REF_INIT, err_sq_avg = 0, busy = 0, valid = 0, accumulators and symbol counter = 0.
- States:
  - IDLE: on start, go to REF_ACC, clear accumulators and counter, clear valid.
  - REF_ACC: on each strobe, add |dec_var| to ref_acc (DW+LOG2_N bits). |-131072| saturates to 131071. After the Nth strobe, ref_lvl <= ref_acc >> LOG2_N (truncate, clamp to 131071), registered the cycle after that strobe; go to ERR_ACC.
  - ERR_ACC: on each strobe, e = dec_var - ref_map. Compute e at DW+1 bits, saturate to DW (range -131072..131071). Add e*e to err_acc (2*DW+LOG2_N bits, unsigned). After the Nth strobe, err_sq_avg <= err_acc >> LOG2_N; go to DONE.
  - DONE: valid = 1, busy = 0. On start, go to REF_ACC (valid clears the same cycle); otherwise hold.
- Counter: LOG2_N+1 bits, counts strobes per phase, reset to 0 on each phase entry.
- Each phase consumes exactly N strobes regardless of gaps between them.
- Slicer thresholds (ties go up):
  - dec_var >= ref_lvl -> 10
  - 0 <= dec_var < ref_lvl -> 11
  - -ref_lvl <= dec_var < 0 -> 01
  - dec_var < -ref_lvl -> 00
- slice is valid in all states. The ERR_ACC error uses ref_map for the same-cycle slice.
- Non-strobe cycles: state, counter and accumulators hold.
- start while busy is ignored.
- start and strobe in the same IDLE cycle: that strobe is not accumulated; the first sample is the next strobe.
- Reset mid-phase: aborts to IDLE, restores REF_INIT, clears valid.
- ref_lvl keeps its last measured value through DONE and IDLE until the next REF_ACC completes or reset.

Optional Feature:
CONT_MEAS_EN.
- Defined: on leaving ERR_ACC, the block goes directly back to ERR_ACC (not DONE), reusing the held ref_lvl. err_sq_avg and valid update each window; busy stays 1. start restarts from REF_ACC; start is not ignored in ERR_ACC.
- Undefined: single-shot behaviour as above.

Test Plan:
1. LOG2_N=4, strobe every cycle, start, dec_var cycling -98304, -32768, 32768, 98304 for 32 strobes, ref_map from reference mapper model -> ref_lvl = 65536 after strobe 16; err_sq_avg = 0 and valid = 1 one cycle after strobe 32.
2. Same as 1, but dec_var +4096 during ERR_ACC -> e = 4096 every symbol, err_sq_avg = 16777216; slice sequence 00, 01, 11, 10.
3. sam_clk_en every 4th cycle, stimulus of test 1 -> identical results; valid rises exactly 1 cycle after the 32nd strobe; nothing changes on non-strobe cycles.
4. start pulsed during REF_ACC and ERR_ACC -> ignored, completion timing unchanged. Reset asserted at strobe 8 -> IDLE, ref_lvl = 65536, valid = 0, busy = 0 next cycle.
5. dec_var = -131072 for all REF_ACC strobes -> ref_lvl = 131071 (saturated). dec_var = 98304, ref_lvl = 65536 -> slice 10; dec_var = -65536 -> slice 01.
6. With CONT_MEAS_EN, stimulus of test 1 held for 64 strobes -> valid stays high from strobe 32, err_sq_avg refreshes after strobes 32, 48 and 64, busy stays 1.
